// File: rtl/miner_pkg.sv
// miner_pkg: shared constants and FSM encoding for the nonce result path
package miner_pkg;
    localparam logic [7:0] HDR_DEFAULT = 8'h4E;
    localparam int FRAME_LEN = 9;
    localparam int NONCE_W = 64;
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BYTES} state_t;
endpackage

// File: rtl/nonce_fifo.sv
// nonce_fifo: synchronous FIFO with wrap-bit pointers and a synchronous clear
module nonce_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]      r_wr, r_rd;
    logic [WIDTH-1:0] r_mem [DEPTH];
    assign count = r_wr - r_rd;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = r_wr == r_rd;
    assign dout  = r_mem[r_rd[AW-1:0]];
    // pointer update; clear wins over any push/pop in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (clr) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (push) r_wr <= r_wr + 1'b1;
            if (pop)  r_rd <= r_rd + 1'b1;
        end
    end
    // storage needs no reset: only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/nonce_reporter.sv
// nonce_reporter: queues published nonces and streams each as a 9-byte framed packet
module nonce_reporter
    import miner_pkg::*;
#(
    parameter int         DEPTH = 4,
    parameter logic [7:0] HDR   = HDR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NONCE_W-1:0]     nonce_bus,
    input  logic                   nonce_bus_wr,
    input  logic                   flush,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic [7:0]             drop_count
);
    state_t             r_state, w_state_nxt;
    logic [NONCE_W-1:0] r_shift, w_shift_nxt, w_head;
    logic [2:0]         r_idx, w_idx_nxt;
    logic [7:0]         w_data_nxt;
    logic               w_valid_nxt, w_full, w_empty, w_hs, w_can_pop, w_pop, w_push, w_drop;

    assign w_hs      = tx_valid & tx_ready;
    assign w_can_pop = !w_empty && !flush;
    assign w_pop     = w_can_pop && (r_state == S_IDLE || (r_state == S_BYTES && w_hs && r_idx == 3'd7));
    assign w_push    = nonce_bus_wr && !flush && (!w_full || w_pop);
    assign w_drop    = nonce_bus_wr && !flush && w_full && !w_pop;

    nonce_fifo #(.DEPTH(DEPTH), .WIDTH(NONCE_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (w_push),
        .pop   (w_pop),
        .din   (nonce_bus),
        .dout  (w_head),
        .count (fifo_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // state register plus the serializer datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_idx    <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_idx    <= w_idx_nxt;
            tx_data  <= w_data_nxt;
            tx_valid <= w_valid_nxt;
        end
    end

    // next state: a finished frame chains straight into the next queued one
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_can_pop) w_state_nxt = S_HDR;
            S_HDR:   if (w_hs) w_state_nxt = S_BYTES;
            S_BYTES: if (w_hs && r_idx == 3'd7) w_state_nxt = w_can_pop ? S_HDR : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // outputs only move on a pop or a handshake, keeping the byte stable under backpressure
    always_comb begin
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_data_nxt  = tx_data;
        w_valid_nxt = tx_valid;
        if (w_pop) begin
            w_shift_nxt = w_head;
            w_data_nxt  = HDR;
            w_valid_nxt = 1'b1;
        end else if (w_hs && r_state == S_HDR) begin
            w_data_nxt = r_shift[7:0];
            w_idx_nxt  = 3'd0;
        end else if (w_hs && r_state == S_BYTES) begin
            if (r_idx != 3'd7) begin
                w_shift_nxt = r_shift >> 8;
                w_idx_nxt   = r_idx + 3'd1;
                w_data_nxt  = r_shift[15:8];
            end else begin
                w_valid_nxt = 1'b0;
            end
        end
    end

    // drop accounting; a flush clears it and swallows any same-cycle write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (flush) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (w_drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end
endmodule

// File: doc/nonce_reporter.md
# nonce_reporter

Receiving end of the miner's nonce result bus. Captures every 64-bit nonce the PoW cores publish on `nonce_bus`/`nonce_bus_wr`, buffers them in a small FIFO, and serializes each one as a 9-byte frame onto a byte stream with a valid/ready handshake. Its output feeds the host link transmitter (UART TX). It is instantiated next to the core controller in the FPGA top level.

## Interface
- `DEPTH`, 4: FIFO entries. Must be a power of 2 and at least 2.
- `HDR`, 8'h4E: header byte that opens every frame.
- `clk`  in  1: single clock for the whole block.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `nonce_bus`  in  64: nonce value from the cores. Valid only while `nonce_bus_wr` is high.
- `nonce_bus_wr`  in  1: one-cycle write strobe. May be high on consecutive cycles.
- `flush`  in  1: one-cycle pulse, driven by job `load`. Discards all queued nonces and clears the status outputs.
- `tx_data`  out  8: byte currently offered to the link.
- `tx_valid`  out  1: `tx_data` is valid.
- `tx_ready`  in  1: link accepts the byte this cycle.
- `fifo_count`  out  $clog2(DEPTH)+1: number of queued nonces, excluding the frame in flight.
- `overflow`  out  1: sticky. Set when a nonce is dropped.
- `drop_count`  out  8: dropped nonces, saturating at 255.

## Operation
- Reset values: `tx_data`=0, `tx_valid`=0, `fifo_count`=0, `overflow`=0, `drop_count`=0. FSM is in IDLE, FIFO pointers are 0.
- Frame format: `HDR`, then nonce bytes in little-endian order (byte0 = `nonce[7:0]` ... byte7 = `nonce[63:56]`). A frame is 9 bytes.
- FIFO write: on a clock edge where `nonce_bus_wr`=1, the entry is pushed if the FIFO is not full. Otherwise the entry is dropped, `overflow` is set to 1, and `drop_count` increments (saturating).
- Simultaneous push and pop on a full FIFO: the pop frees a slot first, so the push succeeds and no drop is recorded.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into a 64-bit shift register, set `tx_data`=`HDR` and `tx_valid`=1, and go to HDR.
  - HDR: on `tx_valid & tx_ready`, set `tx_data` = shift[7:0], clear the byte index to 0, and go to BYTES.
  - BYTES: on handshake with index < 7, shift the register right by 8, increment the index, and present the next byte.
    - On handshake with index == 7, if the FIFO is non-empty, pop the next nonce and present `HDR` in the same edge (go to HDR). There are no idle bubbles between frames.
    - Otherwise drop `tx_valid` to 0 and go to IDLE.
- Handshake rules: once `tx_valid` is asserted, `tx_data` and `tx_valid` stay stable until `tx_ready` is sampled high. `tx_ready` may toggle arbitrarily. `tx_valid` never depends combinationally on `tx_ready`.
- `flush`:
  - Resets the FIFO pointers so that `fifo_count` is 0.
  - Clears `overflow` and `drop_count`.
  - A write arriving in the same cycle is discarded and is not counted as a drop.
  - A frame already in flight (HDR/BYTES) completes unchanged. No frame is ever truncated.
- Reset mid-frame: the frame is abandoned immediately and `tx_valid` drops asynchronously.

## Timing
- A write sampled at edge E is visible in `fifo_count` after E.
- If the FSM is in IDLE, it pops at edge E+1, so `tx_valid`=1 with `tx_data`=`HDR` after E+1.
- With `tx_ready` held at 1, a frame occupies exactly 9 consecutive cycles.
- N queued nonces stream out in 9N cycles with no gaps.
- Throughput limit: one nonce per 9 cycles. A burst longer than `DEPTH`+1 arriving faster than that overflows by design.

## Structure
- Shared package `miner_pkg` holds:
  - the `HDR` default,
  - the frame length constant (9),
  - the nonce width (64),
  - the FSM state enum {IDLE, HDR, BYTES}.
- Sub-module `nonce_fifo`: a synchronous FIFO with parameters `DEPTH`/`WIDTH`, count output, full/empty flags, and a synchronous clear. Pointers carry one extra wrap bit. Reading it combinationally at the head is allowed.
- The serializer FSM, shift register and drop counters live in `nonce_reporter` itself.

## Test plan
- Single nonce 64'h0123456789ABCDEF written, `tx_ready`=1 → bytes 4E EF CD AB 89 67 45 23 01. `tx_valid` rises 2 cycles after the write cycle and falls after the 9th byte.
- Three writes on consecutive cycles, `tx_ready`=1 → 27 contiguous bytes with no `tx_valid` gap, in FIFO order. `fifo_count` peaks at 2.
- Random `tx_ready` backpressure (50%) over 20 nonces → every frame is intact and in order, and `tx_data` is stable while `tx_valid & !tx_ready`.
- `DEPTH`=4, `tx_ready`=0, 7 consecutive writes → the first nonce is in the shift register and 4 are queued. `overflow`=1 and `drop_count`=2. After release, exactly 5 frames go out.
- `flush` pulsed during byte 3 of a frame with 2 nonces queued → the current frame finishes. `fifo_count`=0, `overflow`=0, and no further frames are sent.
- `rst_n` asserted mid-frame → `tx_valid`=0 immediately and all outputs reach their reset values. After release, a new write produces a full frame starting with `HDR`.
